// File: rtl/uart_frame_tx_ctrl_if.sv
// Handshake bundle between the sample source, the frame controller and the
// byte-wide UART transmitter. Signal suffixes are relative to the controller.
interface uart_frame_tx_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             sample_valid_i;
  logic [WIDTH-1:0] sample_i;
  logic             tx_busy_i;
  logic             tx_done_i;
  logic             tx_start_o;
  logic [7:0]       tx_data_o;

  // Controller side: consumes samples and UART status, drives the UART.
  modport master (
    input  sample_valid_i,
    input  sample_i,
    input  tx_busy_i,
    input  tx_done_i,
    output tx_start_o,
    output tx_data_o
  );

  // Environment side: sample producer plus UART core.
  modport slave (
    output sample_valid_i,
    output sample_i,
    output tx_busy_i,
    output tx_done_i,
    input  tx_start_o,
    input  tx_data_o
  );
endinterface

// File: rtl/uart_frame_tx_ctrl.sv
// Frame sequencer in front of the UART transmitter. Buffers signed samples in
// a small FIFO and sends each one as a 4-byte frame:
// sync, high byte, low byte, checksum (sync ^ high ^ low).
module uart_frame_tx_ctrl #(
  parameter int         WIDTH = 16,
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  uart_frame_tx_ctrl_if.master    bus,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  fifo_count_o,
  output logic [7:0]              drop_cnt_o,
  output logic [15:0]             frame_cnt_o
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       frame_q, frame_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              push_s, drop_s, pop_s;

  // Sign-extend a WIDTH-bit sample to the 16-bit frame payload.
  function automatic logic [15:0] sext16(input logic [WIDTH-1:0] v);
    return 16'($signed(v));
  endfunction

  // Frame checksum: XOR of sync and both payload bytes.
  function automatic logic [7:0] frame_csum(input logic [15:0] s);
    return SYNC ^ s[15:8] ^ s[7:0];
  endfunction

  // Byte of the frame selected by its position.
  function automatic logic [7:0] frame_byte(input logic [15:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC;
      2'd1:    b = s[15:8];
      2'd2:    b = s[7:0];
      2'd3:    b = frame_csum(s);
      default: b = SYNC;
    endcase
    return b;
  endfunction

  // FIFO control: fullness is judged on the current count, before any pop.
  always_comb begin
    push_s   = bus.sample_valid_i && (count_q < DEPTH_C);
    drop_s   = bus.sample_valid_i && (count_q >= DEPTH_C);
    pop_s    = (state_q == ST_IDLE) && enable_i && (count_q != {CNT_W{1'b0}});
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Frame sequencer: pop in IDLE, issue one start per byte, advance on done.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    byte_idx_d  = byte_idx_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          frame_d    = mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          state_d    = ST_SEND;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!bus.tx_busy_i) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(frame_q, byte_idx_q);
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (bus.tx_done_i) begin
          if (byte_idx_q == 2'd3) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            byte_idx_d  = byte_idx_q + 2'd1;
            state_d     = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sext16(bus.sample_i);
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      frame_q     <= 16'h0000;
      byte_idx_q  <= 2'd0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      drop_q      <= 8'h00;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      byte_idx_q  <= byte_idx_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.tx_start_o = tx_start_q;
  assign bus.tx_data_o  = tx_data_q;
  assign busy_o         = busy_q;
  assign fifo_count_o   = count_q;
  assign drop_cnt_o     = drop_q;
  assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Self-checking bench for uart_frame_tx_ctrl: a 16-bit and a 12-bit instance,
// each with a simple UART responder, vector tables, hand-written corner-case
// sequences and a randomized phase against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_frame_tx_ctrl;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  typedef struct {
    logic [15:0] s;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic        busy_a, busy_b;
  logic [2:0]  fcnt_a, fcnt_b;
  logic [7:0]  drop_a, drop_b;
  logic [15:0] frm_a, frm_b;

  uart_frame_tx_ctrl_if #(.WIDTH(16)) a_if ();
  uart_frame_tx_ctrl_if #(.WIDTH(12)) b_if ();

  uart_frame_tx_ctrl #(.WIDTH(16), .DEPTH(DEPTH), .SYNC(SYNC)) u_a (
    .clk(clk), .rst(rst), .enable_i(en_a), .bus(a_if.master), .busy_o(busy_a),
    .fifo_count_o(fcnt_a), .drop_cnt_o(drop_a), .frame_cnt_o(frm_a)
  );
  uart_frame_tx_ctrl #(.WIDTH(12), .DEPTH(DEPTH), .SYNC(SYNC)) u_b (
    .clk(clk), .rst(rst), .enable_i(en_b), .bus(b_if.master), .busy_o(busy_b),
    .fifo_count_o(fcnt_b), .drop_cnt_o(drop_b), .frame_cnt_o(frm_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // UART responder models: record every start byte, answer with done later.
  logic       mock_done_a = 1'b0, spur_done_a = 1'b0, mock_done_b = 1'b0;
  int         cd_a = 0, cd_b = 0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  assign a_if.tx_done_i = mock_done_a | spur_done_a;
  assign b_if.tx_done_i = mock_done_b;

  always @(negedge clk) begin
    mock_done_a = 1'b0;
    if (rst) cd_a = 0;
    else begin
      if (cd_a > 0) begin
        cd_a = cd_a - 1;
        if (cd_a == 0) mock_done_a = 1'b1;
      end
      if (a_if.tx_start_o) begin
        got_a.push_back(a_if.tx_data_o);
        cd_a = $urandom_range(3, 1);
      end
    end
  end

  always @(negedge clk) begin
    mock_done_b = 1'b0;
    if (rst) cd_b = 0;
    else begin
      if (cd_b > 0) begin
        cd_b = cd_b - 1;
        if (cd_b == 0) mock_done_b = 1'b1;
      end
      if (b_if.tx_start_o) begin
        got_b.push_back(b_if.tx_data_o);
        cd_b = 2;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame byte, straight from the framing rule.
  function automatic logic [7:0] ref_byte(input logic [15:0] s, input int idx);
    int hi, lo;
    hi = int'(s) / 256;
    lo = int'(s) % 256;
    if (idx == 0) return SYNC;
    if (idx == 1) return 8'(hi);
    if (idx == 2) return 8'(lo);
    return SYNC ^ 8'(hi) ^ 8'(lo);
  endfunction

  function automatic logic [31:0] got_a_at(input int idx);
    if (idx < got_a.size()) return {24'h0, got_a[idx]};
    return 32'hDEAD;
  endfunction

  task automatic strobe_a(input logic [15:0] s);
    a_if.sample_valid_i = 1'b1;
    a_if.sample_i       = s;
    tick();
    a_if.sample_valid_i = 1'b0;
  endtask

  task automatic wait_starts_a(input int n, input int lim);
    int t = 0;
    while (got_a.size() < n && t < lim) begin
      tick();
      t++;
    end
    check("start_timeout", 32'(got_a.size() >= n), 32'd1);
  endtask

  task automatic check_frame_a(input string name, input int base, input logic [15:0] s);
    for (int k = 0; k < 4; k++) check(name, got_a_at(base + k), {24'h0, ref_byte(s, k)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    vec_t        vb[3];
    logic [15:0] ovs[6];
    logic [15:0] rnd_s[$];
    int          base, exp_frm, acc, t;
    logic [15:0] s;

    vecs[0] = '{16'h1234, 8'h12, 8'h34, 8'h83};
    vecs[1] = '{16'h0000, 8'h00, 8'h00, 8'hA5};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hA5};
    vecs[3] = '{16'h8000, 8'h80, 8'h00, 8'h25};
    vecs[4] = '{16'h7FFF, 8'h7F, 8'hFF, 8'h25};
    vecs[5] = '{16'h00FF, 8'h00, 8'hFF, 8'h5A};
    vecs[6] = '{16'hC3A1, 8'hC3, 8'hA1, 8'hC7};
    vb[0]   = '{16'h0800, 8'hF8, 8'h00, 8'h5D};
    vb[1]   = '{16'h07FF, 8'h07, 8'hFF, 8'h5D};
    vb[2]   = '{16'h0123, 8'h01, 8'h23, 8'h87};

    rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
    a_if.sample_valid_i = 1'b0; a_if.sample_i = 16'h0000; a_if.tx_busy_i = 1'b0;
    b_if.sample_valid_i = 1'b0; b_if.sample_i = 12'h000;  b_if.tx_busy_i = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_tx_start", {31'h0, a_if.tx_start_o}, 32'd0);
    check("rst_tx_data",  {24'h0, a_if.tx_data_o},  32'd0);
    check("rst_busy",     {31'h0, busy_a},          32'd0);
    check("rst_fifo_cnt", {29'h0, fcnt_a},          32'd0);
    check("rst_drop_cnt", {24'h0, drop_a},          32'd0);
    check("rst_frame_cnt",{16'h0, frm_a},           32'd0);
    rst = 1'b0;
    tick();

    // Single sample: latency from strobe to first start.
    base = got_a.size();
    strobe_a(16'h1234);
    check("lat_fifo_cnt", {29'h0, fcnt_a}, 32'd1);
    tick();
    check("lat_no_start_yet", {31'h0, a_if.tx_start_o}, 32'd0);
    check("lat_busy", {31'h0, busy_a}, 32'd1);
    tick();
    check("lat_start", {31'h0, a_if.tx_start_o}, 32'd1);
    check("lat_sync",  {24'h0, a_if.tx_data_o},  {24'h0, SYNC});
    wait_starts_a(base + 4, 60);
    check_frame_a("single_frame", base, 16'h1234);
    repeat (6) tick();
    exp_frm = 1;
    check("single_frame_cnt", {16'h0, frm_a}, 32'(exp_frm));

    // Vector table on the 16-bit instance.
    for (int i = 0; i < 7; i++) begin
      base = got_a.size();
      strobe_a(vecs[i].s);
      wait_starts_a(base + 4, 60);
      check("tbl_b0", got_a_at(base),     {24'h0, SYNC});
      check("tbl_b1", got_a_at(base + 1), {24'h0, vecs[i].b1});
      check("tbl_b2", got_a_at(base + 2), {24'h0, vecs[i].b2});
      check("tbl_b3", got_a_at(base + 3), {24'h0, vecs[i].b3});
      repeat (6) tick();
      exp_frm++;
    end
    check("tbl_frame_cnt", {16'h0, frm_a}, 32'(exp_frm));

    // Vector table on the 12-bit instance (sign extension).
    for (int i = 0; i < 3; i++) begin
      base = got_b.size();
      b_if.sample_valid_i = 1'b1;
      b_if.sample_i       = vb[i].s[11:0];
      tick();
      b_if.sample_valid_i = 1'b0;
      t = 0;
      while (got_b.size() < base + 4 && t < 60) begin tick(); t++; end
      check("w12_timeout", 32'(got_b.size() >= base + 4), 32'd1);
      if (got_b.size() >= base + 4) begin
        check("w12_b0", {24'h0, got_b[base]},     {24'h0, SYNC});
        check("w12_b1", {24'h0, got_b[base + 1]}, {24'h0, vb[i].b1});
        check("w12_b2", {24'h0, got_b[base + 2]}, {24'h0, vb[i].b2});
        check("w12_b3", {24'h0, got_b[base + 3]}, {24'h0, vb[i].b3});
      end
      repeat (6) tick();
    end

    // Overflow: UART busy, 6 back-to-back strobes, 5 accepted and 1 dropped.
    base = got_a.size();
    a_if.tx_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ovs[i] = 16'h1000 + 16'(i * 16'h0111);
      a_if.sample_valid_i = 1'b1;
      a_if.sample_i       = ovs[i];
      tick();
    end
    a_if.sample_valid_i = 1'b0;
    tick();
    check("ovf_fifo_cnt", {29'h0, fcnt_a}, 32'd4);
    check("ovf_drop_cnt", {24'h0, drop_a}, 32'd1);
    check("ovf_no_start", 32'(got_a.size()), 32'(base));
    a_if.tx_busy_i = 1'b0;
    wait_starts_a(base + 20, 200);
    for (int f = 0; f < 5; f++) check_frame_a("ovf_order", base + 4 * f, ovs[f]);
    repeat (6) tick();
    exp_frm += 5;
    check("ovf_frame_cnt", {16'h0, frm_a}, 32'(exp_frm));

    // Busy held in SEND for 10 cycles; spurious done in IDLE and in SEND.
    spur_done_a = 1'b1;
    tick();
    spur_done_a = 1'b0;
    base = got_a.size();
    a_if.tx_busy_i = 1'b1;
    strobe_a(16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      spur_done_a = (i == 4);
      tick();
    end
    spur_done_a = 1'b0;
    check("busy_hold_no_start", 32'(got_a.size()), 32'(base));
    a_if.tx_busy_i = 1'b0;
    tick();
    check("busy_release_start", {31'h0, a_if.tx_start_o}, 32'd1);
    check("busy_release_sync",  {24'h0, a_if.tx_data_o},  {24'h0, SYNC});
    tick();
    check("busy_single_pulse",  {31'h0, a_if.tx_start_o}, 32'd0);
    wait_starts_a(base + 4, 60);
    check_frame_a("busy_frame", base, 16'hBEEF);
    check("busy_start_count", 32'(got_a.size()), 32'(base + 4));
    repeat (6) tick();
    exp_frm++;

    // Enable dropped during byte1: frame completes, waiting samples are held.
    base = got_a.size();
    strobe_a(16'h0A0B);
    wait_starts_a(base + 2, 60);
    strobe_a(16'h1111);
    strobe_a(16'h2222);
    en_a = 1'b0;
    wait_starts_a(base + 4, 60);
    repeat (30) tick();
    check("dis_no_new_frame", 32'(got_a.size()), 32'(base + 4));
    check("dis_fifo_cnt", {29'h0, fcnt_a}, 32'd2);
    check("dis_idle",     {31'h0, busy_a}, 32'd0);
    en_a = 1'b1;
    wait_starts_a(base + 12, 120);
    check_frame_a("dis_f0", base,     16'h0A0B);
    check_frame_a("dis_f1", base + 4, 16'h1111);
    check_frame_a("dis_f2", base + 8, 16'h2222);
    repeat (6) tick();
    exp_frm += 3;
    check("dis_frame_cnt", {16'h0, frm_a}, 32'(exp_frm));

    // Reset in WAIT of byte2 with another sample still queued.
    base = got_a.size();
    strobe_a(16'h5A5A);
    strobe_a(16'h3C3C);
    wait_starts_a(base + 3, 60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx_start", {31'h0, a_if.tx_start_o}, 32'd0);
    check("mid_rst_tx_data",  {24'h0, a_if.tx_data_o},  32'd0);
    check("mid_rst_busy",     {31'h0, busy_a},          32'd0);
    check("mid_rst_fifo_cnt", {29'h0, fcnt_a},          32'd0);
    check("mid_rst_drop_cnt", {24'h0, drop_a},          32'd0);
    check("mid_rst_frame_cnt",{16'h0, frm_a},           32'd0);
    repeat (20) tick();
    check("mid_rst_no_start", 32'(got_a.size()), 32'(base + 3));
    exp_frm = 0;

    // Randomized traffic against the frame-level model; strobes are issued
    // only while the queued backlog provably leaves room in the FIFO.
    base = got_a.size();
    acc  = 0;
    for (int c = 0; c < 600; c++) begin
      a_if.tx_busy_i = ($urandom_range(3, 0) == 0);
      if ((acc - (got_a.size() - base + 3) / 4) <= 3 && $urandom_range(2, 0) == 0) begin
        s = 16'($urandom);
        a_if.sample_valid_i = 1'b1;
        a_if.sample_i       = s;
        rnd_s.push_back(s);
        acc++;
      end else begin
        a_if.sample_valid_i = 1'b0;
      end
      tick();
    end
    a_if.sample_valid_i = 1'b0;
    a_if.tx_busy_i      = 1'b0;
    wait_starts_a(base + 4 * acc, 400);
    for (int f = 0; f < acc; f++) check_frame_a("rnd_frame", base + 4 * f, rnd_s[f]);
    check("rnd_byte_total", 32'(got_a.size()), 32'(base + 4 * acc));
    repeat (6) tick();
    exp_frm += acc;
    check("rnd_frame_cnt", {16'h0, frm_a}, 32'(exp_frm));
    check("rnd_drop_cnt",  {24'h0, drop_a}, 32'd0);
    check("rnd_fifo_empty",{29'h0, fcnt_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
